// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO port scheduler.
// The op encoding is the scheduler's one-op-per-cycle state.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_e;

    localparam int FIFO_DEPTH = 16;

    // Counter width able to hold 0..burst inclusive
    function automatic int streak_width(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/fifo_port_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr+1.
// Pointer register advances to the granted index only when en_i is high.
module fifo_port_scheduler_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

    assign ptr_d = en_i ? idx_o : ptr_q;

    // Reset to the last port so port 0 wins the first arbitration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fifo_port_scheduler.sv
// Shares one synchronous FIFO between N_PROD producers and one consumer, one op per cycle.
// Writes arbitrate round-robin; a pending read waits at most WR_BURST write cycles.
module fifo_port_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int N_PROD     = 4,
    parameter int WR_BURST   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PROD-1:0]            prod_valid_i,
    input  logic [N_PROD*DATA_WIDTH-1:0] prod_data_i,
    output logic [N_PROD-1:0]            prod_ready_o,
    input  logic                         cons_req_i,
    output logic                         cons_valid_o,
    output logic [DATA_WIDTH-1:0]        cons_data_o,
    output logic                         fifo_wr_en_o,
    output logic                         fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0]        fifo_d_in_o,
    input  logic [DATA_WIDTH-1:0]        fifo_d_out_i,
    input  logic                         fifo_empty_i,
    input  logic                         fifo_full_i,
    output logic [$clog2(N_PROD)-1:0]    last_grant_o
);
    import fifo_sched_pkg::*;

    localparam int IDX_W    = $clog2(N_PROD);
    localparam int STREAK_W = streak_width(WR_BURST);
    localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(WR_BURST);

    op_e                   op_q, op_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [IDX_W-1:0]      gnt_idx;
    logic [N_PROD-1:0]     gnt;
    logic                  wr_elig, rd_elig;
    logic [DATA_WIDTH-1:0] wr_data;

    fifo_port_scheduler_rr_arbiter #(
        .N     (N_PROD),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (prod_valid_i),
        .en_i  (op_d == OP_WR),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign wr_elig = (|prod_valid_i) && !fifo_full_i;
    assign rd_elig = cons_req_i && !fifo_empty_i;

    // Forcing IDLE under reset gates every combinational output and drops any in-flight read
    always_comb begin
        op_d = OP_IDLE;
        if (rd_elig && (!wr_elig || streak_q == BURST_MAX)) begin
            op_d = OP_RD;
        end else if (wr_elig) begin
            op_d = OP_WR;
        end else if (rd_elig) begin
            op_d = OP_RD;
        end
        if (!rst_n) begin
            op_d = OP_IDLE;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!rd_elig || op_d == OP_RD) begin
            streak_d = '0;
        end else if (op_d == OP_WR && streak_q != BURST_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (gnt[i]) begin
                wr_data = prod_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign last_grant_d = (op_d == OP_WR) ? gnt_idx : last_grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= OP_IDLE;
            streak_q     <= '0;
            last_grant_q <= '0;
        end else begin
            op_q         <= op_d;
            streak_q     <= streak_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign prod_ready_o = (op_d == OP_WR) ? gnt : '0;
    assign fifo_wr_en_o = (op_d == OP_WR);
    assign fifo_rd_en_o = (op_d == OP_RD);
    assign fifo_d_in_o  = (op_d == OP_WR) ? wr_data : '0;
    // FIFO output is registered, so the data beat lines up with the cycle after the pop
    assign cons_valid_o = (op_q == OP_RD);
    assign cons_data_o  = fifo_d_out_i;
    assign last_grant_o = last_grant_q;

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Directed bench for fifo_port_scheduler with a 16-deep synchronous FIFO model.
module tb_fifo_port_scheduler;
    import fifo_sched_pkg::*;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int WB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NP-1:0]  prod_valid = '0;
    logic [NP*DW-1:0] prod_data = '0;
    logic [NP-1:0]  prod_ready;
    logic           cons_req = 1'b0;
    logic           cons_valid;
    logic [DW-1:0]  cons_data;
    logic           fifo_wr_en, fifo_rd_en;
    logic [DW-1:0]  fifo_d_in;
    logic [DW-1:0]  fifo_d_out;
    logic           fifo_empty, fifo_full;
    logic [1:0]     last_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_port_scheduler #(
        .DATA_WIDTH (DW),
        .N_PROD     (NP),
        .WR_BURST   (WB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_valid_i (prod_valid),
        .prod_data_i  (prod_data),
        .prod_ready_o (prod_ready),
        .cons_req_i   (cons_req),
        .cons_valid_o (cons_valid),
        .cons_data_o  (cons_data),
        .fifo_wr_en_o (fifo_wr_en),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_d_in_o  (fifo_d_in),
        .fifo_d_out_i (fifo_d_out),
        .fifo_empty_i (fifo_empty),
        .fifo_full_i  (fifo_full),
        .last_grant_o (last_grant)
    );

    // FIFO model: registered read data, shares the synchronous reset
    logic [DW-1:0] mem [FIFO_DEPTH];
    int            cnt_m = 0;
    int            wp = 0;
    int            rp = 0;
    logic [DW-1:0] f_dout = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_m  <= 0;
            wp     <= 0;
            rp     <= 0;
            f_dout <= '0;
        end else begin
            if (fifo_wr_en && cnt_m < FIFO_DEPTH) begin
                mem[wp] <= fifo_d_in;
                wp      <= (wp + 1) % FIFO_DEPTH;
            end
            if (fifo_rd_en && cnt_m > 0) begin
                f_dout <= mem[rp];
                rp     <= (rp + 1) % FIFO_DEPTH;
            end
            cnt_m <= cnt_m + ((fifo_wr_en && cnt_m < FIFO_DEPTH) ? 1 : 0)
                           - ((fifo_rd_en && cnt_m > 0) ? 1 : 0);
        end
    end

    assign fifo_d_out = f_dout;
    assign fifo_empty = (cnt_m == 0);
    assign fifo_full  = (cnt_m == FIFO_DEPTH);

    // Producer data and expected pop order, maintained from predicted ops only
    logic [DW-1:0] pdata [NP];
    int            seq [NP];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_word = '0;
    bit            exp_cv = 1'b0;

    task automatic pack();
        for (int i = 0; i < NP; i++) prod_data[i*DW +: DW] = pdata[i];
    endtask

    task automatic init_model();
        exp_q.delete();
        exp_cv = 1'b0;
        for (int i = 0; i < NP; i++) begin
            seq[i]   = 0;
            pdata[i] = 8'(i * 16);
        end
        pack();
    endtask

    task automatic commit(input op_e op, input int port);
        exp_cv = 1'b0;
        if (op == OP_WR) begin
            exp_q.push_back(pdata[port]);
            seq[port]++;
            pdata[port] = 8'(port * 16 + seq[port]);
            pack();
        end else if (op == OP_RD) begin
            exp_word = exp_q.pop_front();
            exp_cv   = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        prod_valid = '0;
        cons_req   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        init_model();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        prod_valid = '1;
        cons_req   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (prod_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", prod_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        checks++; if (fifo_d_in !== 8'h00) begin errors++; $display("FAIL reset_d_in: got %h expected 00", fifo_d_in); end
        checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL reset_cons_valid: got %b expected 0", cons_valid); end
        checks++; if (last_grant !== 2'd0) begin errors++; $display("FAIL reset_last_grant: got %0d expected 0", last_grant); end
        rst_n      = 1'b1;
        prod_valid = '0;
        cons_req   = 1'b0;
    endtask

    task automatic test_single_write_read();
        @(negedge clk);
        pdata[2] = 8'h5A;
        pack();
        prod_valid = 4'b0100;
        #1;
        checks++; if (prod_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", prod_ready); end
        checks++; if (fifo_wr_en !== 1'b1 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL single_wr_op: got wr=%b rd=%b expected wr=1 rd=0", fifo_wr_en, fifo_rd_en); end
        checks++; if (fifo_d_in !== 8'h5A) begin errors++; $display("FAIL single_d_in: got %h expected 5a", fifo_d_in); end
        @(posedge clk);
        #1;
        commit(OP_WR, 2);
        prod_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (last_grant !== 2'd2) begin errors++; $display("FAIL single_last_grant: got %0d expected 2", last_grant); end
        checks++; if (prod_ready !== 4'b0000 || fifo_d_in !== 8'h00) begin errors++; $display("FAIL single_idle_outputs: got ready=%b d_in=%h expected 0000/00", prod_ready, fifo_d_in); end
        checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL single_fifo_written: got empty=%b expected 0", fifo_empty); end
        cons_req = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b1 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_rd_op: got rd=%b wr=%b expected rd=1 wr=0", fifo_rd_en, fifo_wr_en); end
        @(posedge clk);
        #1;
        commit(OP_RD, 0);
        cons_req = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (cons_valid !== 1'b1 || cons_data !== exp_word) begin errors++; $display("FAIL single_pop: got valid=%b data=%h expected 1/%h", cons_valid, cons_data, exp_word); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL single_no_extra_rd: got %b expected 0", fifo_rd_en); end
        @(negedge clk);
        #1;
        checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b expected 0", cons_valid); end
    endtask

    task automatic test_rr_fill();
        logic [NP-1:0] exp_r;
        do_reset();
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            @(negedge clk);
            prod_valid = '1;
            cons_req   = 1'b0;
            #1;
            exp_r = 4'b0001 << (k % NP);
            checks++; if (prod_ready !== exp_r) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, prod_ready, exp_r); end
            checks++; if (fifo_wr_en !== 1'b1 || fifo_d_in !== pdata[k % NP]) begin errors++; $display("FAIL rr_write_%0d: got wr=%b d_in=%h expected 1/%h", k, fifo_wr_en, fifo_d_in, pdata[k % NP]); end
            @(posedge clk);
            #1;
            commit(OP_WR, k % NP);
        end
        @(negedge clk);
        #1;
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL rr_full: got %b expected 1", fifo_full); end
        checks++; if (prod_ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rr_full_blocks: got ready=%b wr=%b expected 0000/0", prod_ready, fifo_wr_en); end
        checks++; if (last_grant !== 2'd3) begin errors++; $display("FAIL rr_last_grant: got %0d expected 3", last_grant); end
    endtask

    task automatic test_full_alternate();
        int port = 0;
        logic [NP-1:0] exp_r;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            prod_valid = '1;
            cons_req   = 1'b1;
            #1;
            checks++; if (cons_valid !== exp_cv || (exp_cv && cons_data !== exp_word)) begin errors++; $display("FAIL alt_cons_%0d: got valid=%b data=%h expected %b/%h", k, cons_valid, cons_data, exp_cv, exp_word); end
            if (k % 2 == 0) begin
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL alt_full_%0d: got %b expected 1", k, fifo_full); end
                checks++; if (fifo_rd_en !== 1'b1 || fifo_wr_en !== 1'b0 || prod_ready !== 4'b0000) begin errors++; $display("FAIL alt_rd_%0d: got rd=%b wr=%b ready=%b expected 1/0/0000", k, fifo_rd_en, fifo_wr_en, prod_ready); end
                @(posedge clk);
                #1;
                commit(OP_RD, 0);
            end else begin
                exp_r = 4'b0001 << port;
                checks++; if (fifo_wr_en !== 1'b1 || fifo_rd_en !== 1'b0 || prod_ready !== exp_r) begin errors++; $display("FAIL alt_wr_%0d: got wr=%b rd=%b ready=%b expected 1/0/%b", k, fifo_wr_en, fifo_rd_en, prod_ready, exp_r); end
                checks++; if (fifo_d_in !== pdata[port]) begin errors++; $display("FAIL alt_d_in_%0d: got %h expected %h", k, fifo_d_in, pdata[port]); end
                @(posedge clk);
                #1;
                commit(OP_WR, port);
                port = (port + 1) % NP;
            end
        end
    endtask

    task automatic test_burst_pattern();
        int port = 0;
        logic [NP-1:0] exp_r;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            prod_valid = '1;
            cons_req   = 1'b0;
            #1;
            exp_r = 4'b0001 << (k % NP);
            checks++; if (prod_ready !== exp_r) begin errors++; $display("FAIL burst_fill_%0d: got %b expected %b", k, prod_ready, exp_r); end
            @(posedge clk);
            #1;
            commit(OP_WR, k % NP);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            prod_valid = '1;
            cons_req   = 1'b1;
            #1;
            checks++; if (cons_valid !== exp_cv || (exp_cv && cons_data !== exp_word)) begin errors++; $display("FAIL burst_cons_%0d: got valid=%b data=%h expected %b/%h", k, cons_valid, cons_data, exp_cv, exp_word); end
            if (k % 5 == 4) begin
                checks++; if (fifo_rd_en !== 1'b1 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL burst_rd_%0d: got rd=%b wr=%b expected 1/0", k, fifo_rd_en, fifo_wr_en); end
                @(posedge clk);
                #1;
                commit(OP_RD, 0);
            end else begin
                exp_r = 4'b0001 << port;
                checks++; if (fifo_wr_en !== 1'b1 || fifo_rd_en !== 1'b0 || prod_ready !== exp_r) begin errors++; $display("FAIL burst_wr_%0d: got wr=%b rd=%b ready=%b expected 1/0/%b", k, fifo_wr_en, fifo_rd_en, prod_ready, exp_r); end
                @(posedge clk);
                #1;
                commit(OP_WR, port);
                port = (port + 1) % NP;
            end
        end
        @(negedge clk);
        prod_valid = '0;
        cons_req   = 1'b0;
        #1;
        checks++; if (cons_valid !== 1'b1 || cons_data !== exp_word) begin errors++; $display("FAIL burst_last_pop: got valid=%b data=%h expected 1/%h", cons_valid, cons_data, exp_word); end
    endtask

    task automatic test_empty();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            prod_valid = '0;
            cons_req   = 1'b1;
            #1;
            checks++; if (fifo_rd_en !== 1'b0 || cons_valid !== 1'b0) begin errors++; $display("FAIL empty_%0d: got rd=%b valid=%b expected 0/0", k, fifo_rd_en, cons_valid); end
        end
        cons_req = 1'b0;
    endtask

    task automatic test_reset_during_read();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            prod_valid = '1;
            cons_req   = 1'b0;
            @(posedge clk);
            #1;
            commit(OP_WR, k);
        end
        @(negedge clk);
        prod_valid = '0;
        cons_req   = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rstrd_rd_before: got %b expected 1", fifo_rd_en); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstrd_rd_gated: got %b expected 0", fifo_rd_en); end
        @(posedge clk);
        #1;
        init_model();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL rstrd_no_valid: got %b expected 0", cons_valid); end
        checks++; if (fifo_empty !== 1'b1 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstrd_empty: got empty=%b rd=%b expected 1/0", fifo_empty, fifo_rd_en); end
        prod_valid = '1;
        #1;
        checks++; if (prod_ready !== 4'b0001) begin errors++; $display("FAIL rstrd_rr_restart: got %b expected 0001", prod_ready); end
        @(posedge clk);
        #1;
        prod_valid = '0;
        cons_req   = 1'b0;
    endtask

    initial begin
        init_model();
        test_reset();
        test_single_write_read();
        test_rr_fill();
        test_full_alternate();
        test_burst_pattern();
        test_empty();
        test_reset_during_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
